mem_bus_ctrl: RTL and testbench
===============================

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 3, number of memory banks (bank 0 data, 1 VGA, 2 I/O); legal range 1..8.
REQ-002 SHALL have parameter BANK_AW, default 11, word-address width of each bank; bank size is 2^(BANK_AW+2) bytes.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h10010000, virtual byte address of bank 0; bank i starts at BASE_ADDR + i*2^(BANK_AW+2).
REQ-004 SHALL have parameter WAIT_STATES, default 1, extra cycles held per access; legal range 0..15.
REQ-005 SHALL have ports: clk  in  1  clock, all logic on rising edge.
REQ-006 SHALL have ports: reset  in  1  synchronous, active-low reset.
REQ-007 SHALL have ports: req_valid in 1 request present; req_ready out 1 controller accepts request; req_write in 1 1=store, 0=load.
REQ-008 SHALL have ports: req_addr in 32 virtual byte address; req_wdata in 32 store data, right-aligned; req_size in 2 0=word, 1=half, 2=byte, 3 illegal.
REQ-009 SHALL have ports: req_zext in 1 load extension, 1=zero, 0=sign; rsp_valid out 1 one-cycle completion pulse; rsp_rdata out 32 aligned, extended load data.
REQ-010 SHALL have ports: err out 1 one-cycle error pulse; err_sticky out 1 latched error flag; busy out 1 high whenever state is not IDLE.
REQ-011 SHALL have ports: bank_en out NUM_BANKS one-hot enable; bank_we out 4 byte write strobes; bank_addr out BANK_AW word address; bank_wdata out 32 lane-replicated store data; bank_rdata in 32*NUM_BANKS, bank i in bits [32i+31:32i].

Function
REQ-012 SHALL implement FSM states IDLE, ACCESS, WAIT, RESP, ERR; req_ready=1 only in IDLE.
REQ-013 SHALL accept a request when req_valid and req_ready are both 1 at a rising edge, latching addr, wdata, size, zext and write.
REQ-014 SHALL decode off=req_addr-BASE_ADDR and bank=off>>(BANK_AW+2); the request is invalid if req_addr<BASE_ADDR, bank>=NUM_BANKS or req_size==3.
REQ-015 SHALL go IDLE->ERR on an invalid request, assert err for the single ERR cycle, set err_sticky, assert no bank_en, and return to IDLE.
REQ-016 SHALL go IDLE->ACCESS on a valid request; in ACCESS, bank_en[bank]=1, bank_addr=off[BANK_AW+1:2], and bank_we is nonzero only for stores.
REQ-017 SHALL hold bank_en and bank_addr stable through ACCESS plus WAIT_STATES WAIT cycles, with bank_we forced to 0 in WAIT; ACCESS->RESP directly when WAIT_STATES=0.
REQ-018 SHALL on entry to RESP capture the selected bank_rdata slice, drive rsp_valid=1 for exactly one cycle, then return to IDLE; rsp_valid is also pulsed for stores, with rsp_rdata unchanged.
REQ-019 SHALL give response latency of 2+WAIT_STATES cycles from the accept edge to the rsp_valid cycle; back-to-back throughput is one access per 3+WAIT_STATES cycles.
REQ-020 SHALL generate store strobes as: word 4'b1111; half 4'b0011 (offset bit1=0) or 4'b1100 (offset bit1=1); byte 4'b0001<<off[1:0]. bank_wdata replicates the byte or half to all lanes.
REQ-021 SHALL extract load data little-endian as: byte = lane off[1:0]; half = lanes selected by off[1]; word = the full word. Sign- or zero-extend per req_zext.
REQ-022 SHALL ignore req_valid in all states other than IDLE; the requester holds the request until it is accepted.

Reset
REQ-023 SHALL on reset==0 at any rising edge, including mid-access, enter IDLE and drive bank_en=0, bank_we=0, rsp_valid=0, rsp_rdata=0, err=0, err_sticky=0, busy=0, bank_addr=0, bank_wdata=0.
REQ-024 SHALL clear err_sticky only via reset.

Configuration
REQ-025 SHALL support macro MEM_BUS_CTRL_MISALIGN_CHECK_EN; when defined, a half access with off[0]=1 or a word access with off[1:0]!=0 is invalid and takes the ERR path.
REQ-026 SHALL, without MEM_BUS_CTRL_MISALIGN_CHECK_EN, silently force off[0]=0 for half accesses and off[1:0]=0 for word accesses, with no error raised.

Verification
REQ-027 SHALL verify word load: reset released, WAIT_STATES=1, load word at 0x10010008 with bank0 returning 0xDEADBEEF -> bank_en=3'b001, bank_addr=2, rsp_valid 3 cycles after accept, rsp_rdata=0xDEADBEEF.
REQ-028 SHALL verify byte store: store byte 0x000000A5 to 0x10012003 -> bank_en=3'b010, bank_addr=0, bank_we=4'b1000 for exactly one cycle, bank_wdata=0xA5A5A5A5.
REQ-029 SHALL verify signed half load: load half with req_zext=0 at 0x10014002, bank2 returning 0x8001FFFF -> rsp_rdata=0xFFFF8001; the same load with req_zext=1 -> rsp_rdata=0x00008001.
REQ-030 SHALL verify out-of-range access: load at 0x10016000 with NUM_BANKS=3 -> err pulse of 1 cycle, err_sticky=1, bank_en stays 0, rsp_valid stays 0.
REQ-031 SHALL verify misalignment: with the macro defined, word load at 0x10010002 -> err=1; without the macro -> bank_addr=0 and normal response.
REQ-032 SHALL verify reset mid-operation: reset driven 0 during WAIT -> next edge busy=0, bank_en=0, no rsp_valid pulse; the next request is accepted normally.

Source files
------------

// File: rtl/mem_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_ctrl_if
// Purpose  : Request/response and bank-side bundle for mem_bus_ctrl.
// Revision : 1.0
// ============================================================================
interface mem_bus_ctrl_if #(
    parameter int NUM_BANKS = 3,
    parameter int BANK_AW   = 11
) ();
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [31:0]               req_addr;
    logic [31:0]               req_wdata;
    logic [1:0]                req_size;
    logic                      req_zext;
    logic                      rsp_valid;
    logic [31:0]               rsp_rdata;
    logic                      err;
    logic                      err_sticky;
    logic                      busy;
    logic [NUM_BANKS-1:0]      bank_en;
    logic [3:0]                bank_we;
    logic [BANK_AW-1:0]        bank_addr;
    logic [31:0]               bank_wdata;
    logic [32*NUM_BANKS-1:0]   bank_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_size, req_zext, bank_rdata,
        output req_ready, rsp_valid, rsp_rdata, err, err_sticky, busy,
               bank_en, bank_we, bank_addr, bank_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_size, req_zext, bank_rdata,
        input  req_ready, rsp_valid, rsp_rdata, err, err_sticky, busy,
               bank_en, bank_we, bank_addr, bank_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_ctrl
// Purpose  : Banked memory bus controller with wait states, sub-word access
//            and error reporting. Optional macro MEM_BUS_CTRL_MISALIGN_CHECK_EN
//            turns misaligned half/word accesses into errors.
// Revision : 1.0
// ============================================================================
module mem_bus_ctrl #(
    parameter int          NUM_BANKS   = 3,
    parameter int          BANK_AW     = 11,
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic          clk,
    input  logic          reset,
    mem_bus_ctrl_if.slave bus
);
    localparam int         c_BANK_IW   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int         c_OFF_SHIFT = BANK_AW + 2;
    localparam logic [3:0] c_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RESP   = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_stateNext;

    logic [31:0]           w_off;
    logic [31:0]           w_bankFull;
    logic [1:0]            w_offLow;
    logic                  w_invalid;
    logic [3:0]            w_strb;
    logic [31:0]           w_wdataRep;
    logic                  w_accept;
    logic [NUM_BANKS-1:0]  w_bankEn;
    logic [31:0]           w_sel;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic [31:0]           w_load;

    logic [c_BANK_IW-1:0]  r_bank;
    logic [BANK_AW-1:0]    r_wordAddr;
    logic [1:0]            r_byteOff;
    logic [1:0]            r_size;
    logic                  r_zext;
    logic                  r_write;
    logic [3:0]            r_strb;
    logic [31:0]           r_wdata;
    logic [3:0]            r_waitCnt;
    logic [31:0]           r_rspRdata;
    logic                  r_errSticky;

    // Address decode, alignment and store lane generation for the incoming request
    always_comb begin
        w_off      = bus.req_addr - BASE_ADDR;
        w_bankFull = w_off >> c_OFF_SHIFT;
        w_invalid  = (bus.req_addr < BASE_ADDR) || (w_bankFull >= 32'(NUM_BANKS)) ||
                     (bus.req_size == 2'd3);
`ifdef MEM_BUS_CTRL_MISALIGN_CHECK_EN
        if ((bus.req_size == 2'd1 && w_off[0]) ||
            (bus.req_size == 2'd0 && w_off[1:0] != 2'b00)) begin
            w_invalid = 1'b1;
        end
`endif
        w_offLow   = w_off[1:0];
        w_strb     = 4'b0000;
        w_wdataRep = bus.req_wdata;
        case (bus.req_size)
            2'd0: begin
                w_offLow   = 2'b00;
                w_strb     = 4'b1111;
                w_wdataRep = bus.req_wdata;
            end
            2'd1: begin
                w_offLow   = {w_off[1], 1'b0};
                w_strb     = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdataRep = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                w_offLow   = w_off[1:0];
                w_strb     = 4'b0001 << w_off[1:0];
                w_wdataRep = {4{bus.req_wdata[7:0]}};
            end
        endcase
    end

    assign w_accept = (r_state == ST_IDLE) && bus.req_valid;

    always_comb begin
        w_stateNext   = r_state;
        bus.req_ready = 1'b0;
        bus.busy      = 1'b1;
        bus.rsp_valid = 1'b0;
        bus.err       = 1'b0;
        bus.bank_we   = 4'b0000;
        case (r_state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.req_valid) begin
                    w_stateNext = w_invalid ? ST_ERR : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                bus.bank_we = r_write ? r_strb : 4'b0000;
                w_stateNext = (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (r_waitCnt == 4'd0) begin
                    w_stateNext = ST_RESP;
                end
            end
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                w_stateNext   = ST_IDLE;
            end
            ST_ERR: begin
                bus.err     = 1'b1;
                w_stateNext = ST_IDLE;
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    always_comb begin
        w_bankEn = '0;
        w_sel    = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (r_bank == c_BANK_IW'(i)) begin
                w_bankEn[i] = (r_state == ST_ACCESS) || (r_state == ST_WAIT);
                w_sel       = bus.bank_rdata[32*i +: 32];
            end
        end
    end

    // Little-endian lane extraction with sign or zero extension
    always_comb begin
        w_byte = w_sel[{r_byteOff, 3'b000} +: 8];
        w_half = r_byteOff[1] ? w_sel[31:16] : w_sel[15:0];
        case (r_size)
            2'd1:    w_load = {{16{~r_zext & w_half[15]}}, w_half};
            2'd2:    w_load = {{24{~r_zext & w_byte[7]}}, w_byte};
            default: w_load = w_sel;
        endcase
    end

    assign bus.bank_en    = w_bankEn;
    assign bus.bank_addr  = r_wordAddr;
    assign bus.bank_wdata = r_wdata;
    assign bus.rsp_rdata  = r_rspRdata;
    assign bus.err_sticky = r_errSticky;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bank      <= '0;
            r_wordAddr  <= '0;
            r_byteOff   <= 2'b00;
            r_size      <= 2'b00;
            r_zext      <= 1'b0;
            r_write     <= 1'b0;
            r_strb      <= 4'b0000;
            r_wdata     <= 32'd0;
            r_waitCnt   <= 4'd0;
            r_rspRdata  <= 32'd0;
            r_errSticky <= 1'b0;
        end else begin
            if (w_accept) begin
                r_bank     <= w_bankFull[c_BANK_IW-1:0];
                r_wordAddr <= w_off[BANK_AW+1:2];
                r_byteOff  <= w_offLow;
                r_size     <= bus.req_size;
                r_zext     <= bus.req_zext;
                r_write    <= bus.req_write;
                r_strb     <= w_strb;
                r_wdata    <= w_wdataRep;
            end
            if (r_state == ST_ACCESS) begin
                r_waitCnt <= c_WAIT_LOAD;
            end else if (r_state == ST_WAIT) begin
                r_waitCnt <= r_waitCnt - 4'd1;
            end
            // Stores leave the previous load data visible on the response
            if (w_stateNext == ST_RESP && !r_write) begin
                r_rspRdata <= w_load;
            end
            if (w_stateNext == ST_ERR) begin
                r_errSticky <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_ctrl
// Purpose  : Scoreboard bench for mem_bus_ctrl against a byte-addressed
//            reference memory model.
// Revision : 1.0
// ============================================================================
module tb_mem_bus_ctrl;
    localparam int          NUM_BANKS   = 3;
    localparam int          BANK_AW     = 11;
    localparam logic [31:0] BASE_ADDR   = 32'h1001_0000;
    localparam int          WAIT_STATES = 1;
    localparam int          WORDS       = 1 << BANK_AW;
    localparam int          BANK_BYTES  = WORDS * 4;

    typedef struct {
        bit          isErr;
        logic [31:0] rdata;
        int          cyc;
        bit          sticky;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_bus_ctrl_if #(.NUM_BANKS(NUM_BANKS), .BANK_AW(BANK_AW)) bus ();

    mem_bus_ctrl #(
        .NUM_BANKS  (NUM_BANKS),
        .BANK_AW    (BANK_AW),
        .BASE_ADDR  (BASE_ADDR),
        .WAIT_STATES(WAIT_STATES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int          total = 0;
    int          bad   = 0;
    int          cycle = 0;
    exp_t        expQ[$];
    exp_t        monE;
    logic [7:0]  refMem [NUM_BANKS*BANK_BYTES];
    logic [31:0] mLastRdata;
    bit          mSticky;
    logic [31:0] bankMem [NUM_BANKS][WORDS];
    bit          memInit = 1'b0;
    logic [31:0] initTmp;

    function automatic logic [31:0] initWord(input int b, input int a);
        return (32'(b * WORDS + a + 1) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    always @(posedge clk) cycle <= cycle + 1;

    // Bank memories seen by the controller
    always_comb begin
        for (int i = 0; i < NUM_BANKS; i++) bus.bank_rdata[32*i +: 32] = bankMem[i][bus.bank_addr];
    end

    always @(posedge clk) begin
        if (!memInit) begin
            for (int b = 0; b < NUM_BANKS; b++)
                for (int a = 0; a < WORDS; a++) bankMem[b][a] <= initWord(b, a);
            memInit <= 1'b1;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++)
                if (bus.bank_en[b])
                    for (int k = 0; k < 4; k++)
                        if (bus.bank_we[k]) bankMem[b][bus.bank_addr][8*k +: 8] <= bus.bank_wdata[8*k +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model: flat byte memory, sub-word ops expressed as byte loops
    task automatic modelReq(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [1:0] sz, input bit zx, output exp_t e);
        longint off;
        longint m;
        int     n;
        bit     ok;
        logic [31:0] v;
        off = longint'(addr) - longint'(BASE_ADDR);
        n   = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
        ok  = (off >= 0) && (off < longint'(NUM_BANKS) * BANK_BYTES) && (sz != 2'd3);
`ifdef MEM_BUS_CTRL_MISALIGN_CHECK_EN
        if (ok && (off % n) != 0) ok = 1'b0;
`endif
        if (!ok) begin
            mSticky = 1'b1;
        end else begin
            off = off - (off % n);
            if (wr) begin
                for (int k = 0; k < n; k++) refMem[int'(off) + k] = wd[8*k +: 8];
            end else begin
                v = 32'd0;
                for (int k = 0; k < n; k++) v = v | (32'(refMem[int'(off) + k]) << (8*k));
                m = (64'd1 << (8*n)) - 1;
                if (!zx && v[8*n-1]) v = v | ~32'(m);
                mLastRdata = v;
            end
        end
        e.isErr  = !ok;
        e.rdata  = mLastRdata;
        e.sticky = mSticky;
        e.cyc    = 0;
    endtask

    task automatic doReq(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] sz, input bit zx);
        exp_t e;
        int   guard;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_size  = sz;
        bus.req_zext  = zx;
        guard = 0;
        while (!bus.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_ready", 32'(bus.req_ready), 32'd1);
        if (bus.req_ready) begin
            modelReq(wr, addr, wd, sz, zx, e);
            e.cyc = cycle + (e.isErr ? 1 : 2 + WAIT_STATES);
            expQ.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic waitRsp(output logic [31:0] d);
        int g;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!bus.rsp_valid && g < 20);
        chk("rsp_arrived", 32'(bus.rsp_valid), 32'd1);
        d = bus.rsp_rdata;
    endtask

    // Monitor: every response or error pulse is matched against the scoreboard
    always @(negedge clk) begin
        if (reset && (bus.rsp_valid || bus.err)) begin
            if (expQ.size() == 0) begin
                chk("unexpected_event", 32'({bus.err, bus.rsp_valid}), 32'd0);
            end else begin
                monE = expQ.pop_front();
                chk("event_is_err", 32'(bus.err), 32'(monE.isErr));
                chk("event_cycle", 32'(cycle), 32'(monE.cyc));
                if (!monE.isErr) chk("rsp_rdata", bus.rsp_rdata, monE.rdata);
                chk("err_sticky", 32'(bus.err_sticky), 32'(monE.sticky));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          bnk, wrd, byt, kind;
        logic [31:0] addr;
        logic [1:0]  sz;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        bus.req_size  = 2'd0;
        bus.req_zext  = 1'b0;
        mLastRdata    = 32'd0;
        mSticky       = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++)
            for (int a = 0; a < WORDS; a++) begin
                initTmp = initWord(b, a);
                for (int k = 0; k < 4; k++) refMem[(b*WORDS + a)*4 + k] = initTmp[8*k +: 8];
            end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_bank_en", 32'(bus.bank_en), 32'd0);
        chk("rst_bank_we", 32'(bus.bank_we), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_err_sticky", 32'(bus.err_sticky), 32'd0);
        chk("rst_bank_addr", 32'(bus.bank_addr), 32'd0);
        chk("rst_bank_wdata", bus.bank_wdata, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(bus.req_ready), 32'd1);

        // Word load from bank 0
        doReq(1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 2'd0, 1'b0);
        doReq(1'b0, 32'h1001_0008, 32'd0, 2'd0, 1'b0);
        @(negedge clk);
        chk("wl_bank_en", 32'(bus.bank_en), 32'b001);
        chk("wl_bank_addr", 32'(bus.bank_addr), 32'd2);
        chk("wl_bank_we", 32'(bus.bank_we), 32'd0);
        waitRsp(d);
        chk("wl_rdata", d, 32'hDEAD_BEEF);

        // Byte store to bank 1, strobe only in ACCESS
        doReq(1'b1, 32'h1001_2003, 32'h0000_00A5, 2'd2, 1'b0);
        @(negedge clk);
        chk("bs_bank_en", 32'(bus.bank_en), 32'b010);
        chk("bs_bank_addr", 32'(bus.bank_addr), 32'd0);
        chk("bs_bank_we", 32'(bus.bank_we), 32'b1000);
        chk("bs_bank_wdata", bus.bank_wdata, 32'hA5A5_A5A5);
        @(negedge clk);
        chk("bs_wait_we", 32'(bus.bank_we), 32'd0);
        chk("bs_wait_en", 32'(bus.bank_en), 32'b010);
        waitRsp(d);

        // Signed and unsigned half loads from bank 2
        doReq(1'b1, 32'h1001_4000, 32'h8001_FFFF, 2'd0, 1'b0);
        doReq(1'b0, 32'h1001_4002, 32'd0, 2'd1, 1'b0);
        waitRsp(d);
        chk("hl_signed", d, 32'hFFFF_8001);
        doReq(1'b0, 32'h1001_4002, 32'd0, 2'd1, 1'b1);
        waitRsp(d);
        chk("hl_zext", d, 32'h0000_8001);

        // Out-of-range bank
        doReq(1'b0, 32'h1001_6000, 32'd0, 2'd0, 1'b0);
        @(negedge clk);
        chk("oor_err", 32'(bus.err), 32'd1);
        chk("oor_sticky", 32'(bus.err_sticky), 32'd1);
        chk("oor_bank_en", 32'(bus.bank_en), 32'd0);
        chk("oor_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        chk("oor_err_end", 32'(bus.err), 32'd0);
        chk("oor_sticky_hold", 32'(bus.err_sticky), 32'd1);
        chk("oor_bank_en_end", 32'(bus.bank_en), 32'd0);

        // Misaligned word load
        doReq(1'b0, 32'h1001_0002, 32'd0, 2'd0, 1'b0);
        @(negedge clk);
`ifdef MEM_BUS_CTRL_MISALIGN_CHECK_EN
        chk("mis_err", 32'(bus.err), 32'd1);
`else
        chk("mis_bank_addr", 32'(bus.bank_addr), 32'd0);
        chk("mis_bank_en", 32'(bus.bank_en), 32'b001);
        waitRsp(d);
`endif

        // Reset during WAIT abandons the access
        doReq(1'b0, 32'h1001_0008, 32'd0, 2'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("mid_busy_before", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_busy", 32'(bus.busy), 32'd0);
        chk("mid_bank_en", 32'(bus.bank_en), 32'd0);
        chk("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_sticky", 32'(bus.err_sticky), 32'd0);
        void'(expQ.pop_back());
        mLastRdata = 32'd0;
        mSticky    = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        doReq(1'b0, 32'h1001_0008, 32'd0, 2'd0, 1'b0);
        waitRsp(d);
        chk("post_rst_rdata", d, 32'hDEAD_BEEF);

        // Randomized traffic
        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 19);
            bnk  = $urandom_range(0, NUM_BANKS - 1);
            wrd  = $urandom_range(0, 15);
            byt  = $urandom_range(0, 3);
            sz   = 2'($urandom_range(0, 2));
            addr = BASE_ADDR + 32'(bnk * BANK_BYTES + wrd * 4 + byt);
            if (kind == 0) sz = 2'd3;
            else if (kind == 1) addr = BASE_ADDR + 32'(NUM_BANKS * BANK_BYTES + wrd * 4 + byt);
            else if (kind == 2) addr = BASE_ADDR - 32'($urandom_range(1, 64));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            doReq(1'($urandom_range(0, 1)), addr, $urandom, sz, 1'($urandom_range(0, 1)));
        end

        repeat (10) @(negedge clk);
        chk("scoreboard_drain", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
